// File: rtl/symbol_sampler.sv
// Generic show-ahead synchronous FIFO; head entry is presented combinationally on out_dat.
// Latency: a push is visible at the head one cycle after its edge; a pop advances the head on the accepting edge.
// Backpressure: a push into a full FIFO is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         full,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;
    logic          wr;

    assign out_vld = (cnt_q != '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
    assign pop     = out_vld & out_rdy;
    // When full, the slot being written is the one popped this cycle.
    assign wr      = in_vld & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// Symbol decision, period-based lock detection and MSB-first byte packing behind a show-ahead FIFO.
// Latency: decision registered on the strobe edge; a completed byte reaches byte_out one edge after its 8th bit.
// Backpressure: byte_valid/byte_ready; up to FIFO_DEPTH bytes buffered, further bytes dropped with sticky overflow.
module symbol_sampler #(
    parameter int FIFO_DEPTH = 4,
    parameter int PMIN       = 3,
    parameter int PMAX       = 5,
    parameter int LOCK_CNT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x_in,
    input  logic        clk_7p68MHz,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        locked,
    output logic        overflow
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [7:0]    PMIN_B = 8'(PMIN);
    localparam logic [7:0]    PMAX_B = 8'(PMAX);
    localparam logic [GW-1:0] LOCK_B = GW'(LOCK_CNT);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t   state_q, state_d;
    logic          sym_q, sym_d;
    logic [7:0]    per_q, per_d;
    logic          armed_q, armed_d;
    logic [GW-1:0] good_q, good_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          push_q, push_d;
    logic          ovf_q, ovf_d;

    logic strobe;
    logic dec_bit;
    logic in_range;
    logic judged;
    logic bad;
    logic fifo_full;
    logic fifo_pop;
    logic unused_x_in;

    assign strobe      = clk_7p68MHz & ~sym_q;
    assign dec_bit     = ~x_in[15];
    assign unused_x_in = ^x_in[14:0];
    // per_q still holds the pre-clear count on the strobe cycle, i.e. the measured period.
    assign in_range    = (per_q >= PMIN_B) && (per_q <= PMAX_B);
    assign judged      = strobe & armed_q;
    assign bad         = judged & ~in_range;
    assign fifo_pop    = byte_valid & byte_ready;

    always_comb begin
        sym_d     = clk_7p68MHz;
        per_d     = per_q;
        armed_d   = armed_q;
        good_d    = good_q;
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        push_d    = 1'b0;
        ovf_d     = ovf_q | (push_q & fifo_full & ~fifo_pop);

        if (per_q != 8'hFF) begin
            per_d = per_q + 8'd1;
        end
        if (strobe) begin
            per_d   = 8'd1;
            armed_d = 1'b1;
        end

        if (judged) begin
            if (in_range) begin
                if (good_q != LOCK_B) begin
                    good_d = good_q + GW'(1);
                end
                if (good_d == LOCK_B) begin
                    state_d = LOCKED;
                end
            end else begin
                good_d  = '0;
                state_d = UNLOCKED;
            end
        end

        // Only strobes seen while already locked pack; an unlocking strobe discards the partial byte.
        if (bad) begin
            sh_d      = '0;
            bit_cnt_d = '0;
        end else if (strobe && (state_q == LOCKED)) begin
            sh_d      = {sh_q[6:0], dec_bit};
            bit_cnt_d = bit_cnt_q + 3'd1;
            push_d    = (bit_cnt_q == 3'd7);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= UNLOCKED;
            sym_q     <= 1'b0;
            per_q     <= '0;
            armed_q   <= 1'b0;
            good_q    <= '0;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            push_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_q     <= sym_d;
            per_q     <= per_d;
            armed_q   <= armed_d;
            good_q    <= good_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            push_q    <= push_d;
            ovf_q     <= ovf_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign overflow = ovf_q;

    // sh_q is stable on the push edge: no strobe can follow its own strobe cycle directly.
    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (push_q),
        .in_dat  (sh_q),
        .full    (fifo_full),
        .out_vld (byte_valid),
        .out_rdy (byte_ready),
        .out_dat (byte_out)
    );
endmodule

// File: tb/tb_symbol_sampler.sv
// Bench for symbol_sampler: directed scenarios plus randomized strobe periods, checked against a strobe-level model.
module tb_symbol_sampler;
    localparam int DEPTH = 4;
    localparam int PMIN  = 3;
    localparam int PMAX  = 5;
    localparam int LCNT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_sym;
    logic        byte_ready;
    logic [15:0] x_in;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        locked;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    bit         m_sym, m_armed, m_locked, m_ovf, m_pend;
    int         m_good, m_last, cyc;
    bit         m_bits[$];
    logic [7:0] mq[$];
    logic [7:0] m_pend_byte;
    logic [7:0] got_q[$];
    bit         rand_ready = 1'b0;

    symbol_sampler #(
        .FIFO_DEPTH (DEPTH),
        .PMIN       (PMIN),
        .PMAX       (PMAX),
        .LOCK_CNT   (LCNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .clk_7p68MHz (clk_sym),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .locked      (locked),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Strobe-level reference: periods from edge indices, bytes from a bit queue, FIFO as a byte queue.
    task automatic model_run();
        bit pop, was_full, was_locked, strobe, bad;
        int period;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_sym = 0; m_armed = 0; m_locked = 0; m_ovf = 0; m_pend = 0; m_good = 0;
                m_bits.delete();
                mq.delete();
            end else begin
                was_full = (mq.size() == DEPTH);
                pop = (mq.size() != 0) && (byte_ready === 1'b1);
                if (pop) void'(mq.pop_front());
                if (m_pend) begin
                    if (was_full && !pop) m_ovf = 1;
                    else mq.push_back(m_pend_byte);
                end
                m_pend = 0;
                strobe = clk_sym && !m_sym;
                m_sym = clk_sym;
                if (strobe) begin
                    was_locked = m_locked;
                    bad = 0;
                    if (m_armed) begin
                        period = (cyc - m_last > 255) ? 255 : cyc - m_last;
                        if (period >= PMIN && period <= PMAX) begin
                            if (m_good < LCNT) m_good++;
                            if (m_good == LCNT) m_locked = 1;
                        end else begin
                            bad = 1; m_good = 0; m_locked = 0;
                        end
                    end
                    m_armed = 1;
                    m_last = cyc;
                    if (bad) m_bits.delete();
                    else if (was_locked) begin
                        m_bits.push_back(~x_in[15]);
                        if (m_bits.size() == 8) begin
                            m_pend_byte = 8'h00;
                            foreach (m_bits[i]) m_pend_byte = {m_pend_byte[6:0], m_bits[i]};
                            m_pend = 1;
                            m_bits.delete();
                        end
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            n_chk++; if (locked !== m_locked) begin n_fail++; $display("FAIL mon_locked cyc=%0d: got %b expected %b", cyc, locked, m_locked); end
            n_chk++; if (byte_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL mon_valid cyc=%0d: got %b expected %b", cyc, byte_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_chk++; if (byte_out !== mq[0]) begin n_fail++; $display("FAIL mon_byte cyc=%0d: got %h expected %h", cyc, byte_out, mq[0]); end
            end
            n_chk++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL mon_overflow cyc=%0d: got %b expected %b", cyc, overflow, m_ovf); end
            if (byte_valid === 1'b1 && byte_ready === 1'b1) got_q.push_back(byte_out);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) byte_ready = 1'($urandom);
    endtask

    function automatic logic [15:0] bit_x(input logic b);
        logic [14:0] m = 15'($urandom);
        return b ? {1'b0, m} : {1'b1, m};
    endfunction

    // One symbol period: strobe cycle carries x, remaining cycles carry noise.
    task automatic sym_period(input int p, input logic [15:0] x);
        int hi = (p / 2 < 1) ? 1 : p / 2;
        for (int i = 0; i < p; i++) begin
            clk_sym = (i < hi);
            x_in = (i == 0) ? x : 16'($urandom);
            tick();
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) sym_period(4, bit_x(b[7-i]));
    endtask

    task automatic reset_pulse();
        reset = 1'b1; clk_sym = 1'b0;
        tick(); tick();
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic lock_up();
        reset_pulse();
        repeat (17) sym_period(4, 16'($urandom));
        n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lockup_locked: got %b expected 1", locked); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_sym = 1'($urandom); x_in = 16'($urandom); byte_ready = 1'($urandom);
            tick();
            n_chk++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL rst_byte_out: got %h expected 00", byte_out); end
            n_chk++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", byte_valid); end
            n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked); end
            n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        end
        reset = 1'b0; clk_sym = 1'b0; byte_ready = 1'b1;
        tick();
        for (int k = 1; k <= LCNT; k++) begin
            sym_period(4, 16'($urandom));
            n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_no_early_lock strobe %0d: got %b expected 0", k, locked); end
        end
    endtask

    task automatic test_acquisition();
        reset_pulse();
        byte_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            sym_period(4, 16'($urandom));
            n_chk++; if (locked !== 1'(k == 17)) begin n_fail++; $display("FAIL acq_locked strobe %0d: got %b expected %b", k, locked, k == 17); end
        end
        for (int i = 1; i <= 7; i++) sym_period(4, (i % 2 == 1) ? 16'd1000 : 16'hFC18);
        clk_sym = 1'b1; x_in = 16'hFC18;
        tick();
        n_chk++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL acq_valid_early: got %b expected 0", byte_valid); end
        x_in = 16'($urandom);
        tick();
        n_chk++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL acq_valid_rise: got %b expected 1", byte_valid); end
        n_chk++; if (byte_out !== 8'hAA) begin n_fail++; $display("FAIL acq_first_byte: got %h expected aa", byte_out); end
        clk_sym = 1'b0;
        tick(); tick();
    endtask

    task automatic test_lock_loss();
        send_bits(8'hF8, 4);
        sym_period(7, bit_x(1'b1));
        sym_period(4, bit_x(1'b1));
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_unlock: got %b expected 0", locked); end
        for (int k = 1; k <= 16; k++) begin
            sym_period(4, 16'($urandom));
            n_chk++; if (locked !== 1'(k == 16)) begin n_fail++; $display("FAIL loss_relock strobe %0d: got %b expected %b", k, locked, k == 16); end
        end
        send_bits(8'h3C, 8);
        tick(); tick();
        n_chk++; if (got_q.size() != 2) begin n_fail++; $display("FAIL loss_byte_count: got %0d expected 2", got_q.size()); end
        else begin
            n_chk++; if (got_q[1] !== 8'h3C) begin n_fail++; $display("FAIL loss_fresh_byte: got %h expected 3c", got_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        lock_up();
        byte_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_bits(8'(i), 8);
            if (i == 4) begin
                n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovf_at_4: got %b expected 0", overflow); end
            end
        end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_at_5: got %b expected 1", overflow); end
        n_chk++; if (byte_valid !== 1'b1 || byte_out !== 8'h01) begin n_fail++; $display("FAIL bp_head: got v=%b %h expected v=1 01", byte_valid, byte_out); end
        byte_ready = 1'b1;
        repeat (8) tick();
        n_chk++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_chk++; if (got_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[i], i + 1); end
        end
        n_chk++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", byte_valid); end
    endtask

    task automatic test_full_pop();
        lock_up();
        byte_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_bits(8'hA1 + 8'(i), 8);
        send_bits(8'hA5, 7);
        clk_sym = 1'b1; x_in = bit_x(1'b1);
        tick();
        byte_ready = 1'b1; x_in = 16'($urandom);
        tick();
        byte_ready = 1'b0; clk_sym = 1'b0;
        tick(); tick();
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_overflow: got %b expected 0", overflow); end
        n_chk++; if (byte_valid !== 1'b1 || byte_out !== 8'hA2) begin n_fail++; $display("FAIL fp_head: got v=%b %h expected v=1 a2", byte_valid, byte_out); end
        byte_ready = 1'b1;
        repeat (8) tick();
        n_chk++; if (got_q.size() != 5) begin n_fail++; $display("FAIL fp_count: got %0d expected 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            n_chk++; if (got_q[i] !== 8'hA1 + 8'(i)) begin n_fail++; $display("FAIL fp_order[%0d]: got %h expected %h", i, got_q[i], 8'hA1 + 8'(i)); end
        end
    endtask

    task automatic test_boundaries();
        lock_up();
        byte_ready = 1'b1;
        sym_period(4, 16'h0000);
        sym_period(4, 16'h7FFF);
        sym_period(4, 16'hFFFF);
        sym_period(4, 16'h8000);
        sym_period(4, bit_x(1'b1));
        sym_period(4, bit_x(1'b0));
        sym_period(4, bit_x(1'b1));
        sym_period(4, bit_x(1'b0));
        repeat (3) tick();
        n_chk++; if (got_q.size() != 1 || got_q[0] !== 8'hCA) begin n_fail++; $display("FAIL bnd_byte: got n=%0d %h expected n=1 ca", got_q.size(), got_q.size() ? got_q[0] : 8'h00); end
    endtask

    task automatic test_reset_mid();
        lock_up();
        byte_ready = 1'b0;
        send_bits(8'h5A, 8);
        send_bits(8'hFF, 3);
        n_chk++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL rm_buffered: got %b expected 1", byte_valid); end
        reset_pulse();
        n_chk++; if (byte_valid !== 1'b0 || byte_out !== 8'h00) begin n_fail++; $display("FAIL rm_flushed: got v=%b %h expected v=0 00", byte_valid, byte_out); end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rm_locked: got %b expected 0", locked); end
        byte_ready = 1'b1;
        repeat (17) sym_period(4, 16'($urandom));
        send_bits(8'h81, 8);
        repeat (3) tick();
        n_chk++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin n_fail++; $display("FAIL rm_fresh: got n=%0d %h expected n=1 81", got_q.size(), got_q.size() ? got_q[0] : 8'h00); end
    endtask

    task automatic test_random();
        int r, p;
        reset_pulse();
        rand_ready = 1'b1;
        repeat (400) begin
            r = $urandom_range(0, 59);
            p = (r == 0) ? 2 : (r == 1) ? 6 : (r == 2) ? 7 : $urandom_range(3, 5);
            sym_period(p, 16'($urandom));
        end
        rand_ready = 1'b0;
        byte_ready = 1'b1;
        repeat (10) tick();
        n_chk++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drained: got %b expected 0", byte_valid); end
    endtask

    initial begin
        reset = 1'b1; clk_sym = 1'b0; x_in = '0; byte_ready = 1'b0;
        fork
            model_run();
            monitor();
        join_none
        test_reset();
        test_acquisition();
        test_lock_loss();
        test_backpressure();
        test_full_pop();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
